// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: source indices, request record and a lowest-set-bit helper
// shared by the writeback arbiter and its round-robin picker.
package wb_arb_pkg;
    localparam int WB_SRC_IP0 = 0;
    localparam int WB_SRC_IP1 = 1;
    localparam int WB_SRC_LSP = 2;
    localparam int WB_SRC_MD  = 3;
    localparam int WB_NUM_SRC = 4;

    typedef struct packed {
        logic [4:0]  dst;
        logic [63:0] result;
        logic [63:0] pc;
        logic        wb_en;
    } wb_req_t;

    function automatic logic [1:0] wb_lowest(input logic [WB_NUM_SRC-1:0] m);
        wb_lowest = 2'd0;
        for (int k = WB_NUM_SRC - 1; k >= 0; k--)
            if (m[k]) wb_lowest = 2'(k);
    endfunction
endpackage

// File: rtl/wb_arb_if.sv
// wb_arb_if: writeback handshake from the four pipes plus the register-file
// write port and retire trace; slave is the arbiter side, master the pipes.
interface wb_arb_if;
    logic [4:0]  ip0_wb_dst, ip1_wb_dst, lsp_wb_dst, md_wb_dst;
    logic [63:0] ip0_wb_result, ip1_wb_result, lsp_wb_result, md_wb_result;
    logic [63:0] ip0_wb_pc, ip1_wb_pc, lsp_wb_pc, md_wb_pc;
    logic        ip0_wb_wb_en, ip1_wb_wb_en, lsp_wb_wb_en, md_wb_wb_en;
    logic        ip0_wb_hipri, ip1_wb_hipri;
    logic        ip0_wb_valid, ip1_wb_valid, lsp_wb_valid, md_wb_valid;
    logic        ip0_wb_ready, ip1_wb_ready, lsp_wb_ready, md_wb_ready;
    logic        wb_hold;
    logic        wb_rf_wen;
    logic [4:0]  wb_rf_dst;
    logic [63:0] wb_rf_value;
    logic        wb_trace_valid;
    logic [63:0] wb_trace_pc;
    logic [63:0] wb_retire_count;

    modport slave (
        input  ip0_wb_dst, ip0_wb_result, ip0_wb_pc, ip0_wb_wb_en, ip0_wb_hipri, ip0_wb_valid,
        input  ip1_wb_dst, ip1_wb_result, ip1_wb_pc, ip1_wb_wb_en, ip1_wb_hipri, ip1_wb_valid,
        input  lsp_wb_dst, lsp_wb_result, lsp_wb_pc, lsp_wb_wb_en, lsp_wb_valid,
        input  md_wb_dst, md_wb_result, md_wb_pc, md_wb_wb_en, md_wb_valid,
        input  wb_hold,
        output ip0_wb_ready, ip1_wb_ready, lsp_wb_ready, md_wb_ready,
        output wb_rf_wen, wb_rf_dst, wb_rf_value, wb_trace_valid, wb_trace_pc, wb_retire_count
    );

    modport master (
        output ip0_wb_dst, ip0_wb_result, ip0_wb_pc, ip0_wb_wb_en, ip0_wb_hipri, ip0_wb_valid,
        output ip1_wb_dst, ip1_wb_result, ip1_wb_pc, ip1_wb_wb_en, ip1_wb_hipri, ip1_wb_valid,
        output lsp_wb_dst, lsp_wb_result, lsp_wb_pc, lsp_wb_wb_en, lsp_wb_valid,
        output md_wb_dst, md_wb_result, md_wb_pc, md_wb_wb_en, md_wb_valid,
        output wb_hold,
        input  ip0_wb_ready, ip1_wb_ready, lsp_wb_ready, md_wb_ready,
        input  wb_rf_wen, wb_rf_dst, wb_rf_value, wb_trace_valid, wb_trace_pc, wb_retire_count
    );
endinterface

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: combinational 4-way round-robin picker; the source after ptr
// has highest priority and ptr itself the lowest.
module wb_rr_pick
    import wb_arb_pkg::*;
(
    input  logic [WB_NUM_SRC-1:0] valid,
    input  logic [1:0]            ptr,
    output logic [WB_NUM_SRC-1:0] gnt,
    output logic [1:0]            idx
);
    always_comb begin
        idx = ptr;
        for (int k = WB_NUM_SRC; k >= 1; k--)
            if (valid[ptr + 2'(k)]) idx = ptr + 2'(k);
        gnt = |valid ? WB_NUM_SRC'(1) << idx : '0;
    end
endmodule

// File: rtl/wb_arb.sv
// wb_arb: writeback arbiter granting one of ip0/ip1/lsp/md per cycle to a
// registered register-file write port, with starvation override and retire count.
module wb_arb
    import wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input logic     clk,
    input logic     rst,
    wb_arb_if.slave bus
);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

    wb_req_t               req [WB_NUM_SRC];
    wb_req_t               sel;
    logic [CNT_W-1:0]      starve [WB_NUM_SRC];
    logic [WB_NUM_SRC-1:0] valid, hipri, starved, rr_gnt, gnt;
    logic [1:0]            rr_ptr, rr_idx, gnt_idx;
    logic                  active, gnt_any;

    assign req[WB_SRC_IP0] = '{bus.ip0_wb_dst, bus.ip0_wb_result, bus.ip0_wb_pc, bus.ip0_wb_wb_en};
    assign req[WB_SRC_IP1] = '{bus.ip1_wb_dst, bus.ip1_wb_result, bus.ip1_wb_pc, bus.ip1_wb_wb_en};
    assign req[WB_SRC_LSP] = '{bus.lsp_wb_dst, bus.lsp_wb_result, bus.lsp_wb_pc, bus.lsp_wb_wb_en};
    assign req[WB_SRC_MD]  = '{bus.md_wb_dst, bus.md_wb_result, bus.md_wb_pc, bus.md_wb_wb_en};

    assign valid   = {bus.md_wb_valid, bus.lsp_wb_valid, bus.ip1_wb_valid, bus.ip0_wb_valid};
    assign hipri   = {2'b00, bus.ip1_wb_hipri, bus.ip0_wb_hipri} & valid;
    assign active  = rst && !bus.wb_hold;
    assign gnt_any = active && |valid;

    wb_rr_pick u_pick (.valid(valid), .ptr(rr_ptr), .gnt(rr_gnt), .idx(rr_idx));

    // Starvation beats hipri, which beats round-robin.
    always_comb begin
        for (int k = 0; k < WB_NUM_SRC; k++)
            starved[k] = valid[k] && starve[k] == LIM;
        gnt_idx = |starved ? wb_lowest(starved) : |hipri ? wb_lowest(hipri) : rr_idx;
        gnt     = !gnt_any ? '0 : (|starved || |hipri) ? WB_NUM_SRC'(1) << gnt_idx : rr_gnt;
        sel     = req[gnt_idx];
    end

    assign bus.ip0_wb_ready = active && (!valid[WB_SRC_IP0] || gnt[WB_SRC_IP0]);
    assign bus.ip1_wb_ready = active && (!valid[WB_SRC_IP1] || gnt[WB_SRC_IP1]);
    assign bus.lsp_wb_ready = active && (!valid[WB_SRC_LSP] || gnt[WB_SRC_LSP]);
    assign bus.md_wb_ready  = active && (!valid[WB_SRC_MD] || gnt[WB_SRC_MD]);

    // Refusals during wb_hold still count toward starvation.
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int k = 0; k < WB_NUM_SRC; k++) starve[k] <= '0;
        else
            for (int k = 0; k < WB_NUM_SRC; k++)
                starve[k] <= (!valid[k] || gnt[k]) ? '0 : starve[k] + CNT_W'(starve[k] != LIM);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rr_ptr              <= 2'd3;
            bus.wb_rf_wen       <= 1'b0;
            bus.wb_rf_dst       <= '0;
            bus.wb_rf_value     <= '0;
            bus.wb_trace_valid  <= 1'b0;
            bus.wb_trace_pc     <= '0;
            bus.wb_retire_count <= '0;
        end else begin
            bus.wb_rf_wen      <= gnt_any && sel.wb_en && sel.dst != 5'd0;
            bus.wb_trace_valid <= gnt_any;
            if (gnt_any) begin
                rr_ptr              <= gnt_idx;
                bus.wb_rf_dst       <= sel.dst;
                bus.wb_rf_value     <= sel.result;
                bus.wb_trace_pc     <= sel.pc;
                bus.wb_retire_count <= bus.wb_retire_count + 64'd1;
            end
        end
endmodule

// File: tb/tb_wb_arb.sv
// tb_wb_arb: table vectors, directed corner sequences and random traffic
// checked against a rule-level arbiter model.
module tb_wb_arb;
    import wb_arb_pkg::*;

    localparam int LIM = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    wb_arb_if bus ();

    wb_arb #(.STARVE_LIMIT(LIM), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic        s_valid [4];
    logic        s_hi    [4];
    logic        s_en    [4];
    logic [4:0]  s_dst   [4];
    logic [63:0] s_res   [4];
    logic [63:0] s_pc    [4];
    logic        hold;

    int          m_cnt [4];
    int          m_last;
    logic [63:0] m_count, m_val, m_pc;
    logic [4:0]  m_dst;
    logic        m_wen, m_tv;

    typedef struct {
        logic [3:0] valid;
        logic [1:0] hi;
        logic       hold;
        logic [3:0] er;
        int         g;
        logic       wen;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h want %h", n, act, exp);
        else passed++;
    endtask

    function automatic logic [3:0] rdy();
        return {bus.md_wb_ready, bus.lsp_wb_ready, bus.ip1_wb_ready, bus.ip0_wb_ready};
    endfunction

    task automatic apply();
        bus.ip0_wb_valid = s_valid[0]; bus.ip0_wb_hipri = s_hi[0]; bus.ip0_wb_wb_en = s_en[0];
        bus.ip0_wb_dst = s_dst[0]; bus.ip0_wb_result = s_res[0]; bus.ip0_wb_pc = s_pc[0];
        bus.ip1_wb_valid = s_valid[1]; bus.ip1_wb_hipri = s_hi[1]; bus.ip1_wb_wb_en = s_en[1];
        bus.ip1_wb_dst = s_dst[1]; bus.ip1_wb_result = s_res[1]; bus.ip1_wb_pc = s_pc[1];
        bus.lsp_wb_valid = s_valid[2]; bus.lsp_wb_wb_en = s_en[2];
        bus.lsp_wb_dst = s_dst[2]; bus.lsp_wb_result = s_res[2]; bus.lsp_wb_pc = s_pc[2];
        bus.md_wb_valid = s_valid[3]; bus.md_wb_wb_en = s_en[3];
        bus.md_wb_dst = s_dst[3]; bus.md_wb_result = s_res[3]; bus.md_wb_pc = s_pc[3];
        bus.wb_hold = hold;
    endtask

    function automatic void set_data();
        for (int i = 0; i < 4; i++) begin
            s_dst[i] = (i == 3) ? 5'd0 : 5'(5 + i);
            s_res[i] = 64'h1000 + 64'(i);
            s_pc[i]  = 64'h8000 + 64'(4 * i);
            s_en[i]  = 1'b1;
            s_hi[i]  = 1'b0;
        end
    endfunction

    function automatic void mreset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_last = 3; m_count = '0; m_val = '0; m_pc = '0; m_dst = '0; m_wen = 1'b0; m_tv = 1'b0;
    endfunction

    function automatic int mgrant();
        if (!rst || hold) return -1;
        for (int i = 0; i < 4; i++) if (s_valid[i] && m_cnt[i] == LIM) return i;
        for (int i = 0; i < 2; i++) if (s_valid[i] && s_hi[i]) return i;
        for (int k = 1; k <= 4; k++) if (s_valid[(m_last + k) % 4]) return (m_last + k) % 4;
        return -1;
    endfunction

    function automatic void mupdate(input int g);
        for (int i = 0; i < 4; i++)
            m_cnt[i] = (!s_valid[i] || g == i) ? 0 : (m_cnt[i] < LIM ? m_cnt[i] + 1 : LIM);
        m_tv  = g >= 0;
        m_wen = 1'b0;
        if (g >= 0) begin
            m_wen = s_en[g] && s_dst[g] != 5'd0;
            m_last = g; m_count = m_count + 64'd1;
            m_dst = s_dst[g]; m_val = s_res[g]; m_pc = s_pc[g];
        end
    endfunction

    task automatic step(input string n, output int g);
        logic [3:0] er;
        apply();
        #3;
        g = mgrant();
        for (int i = 0; i < 4; i++) er[i] = rst && !hold && (!s_valid[i] || g == i);
        chk({n, " ready"}, 64'(rdy()), 64'(er));
        @(posedge clk); #1;
        mupdate(g);
        chk({n, " wen"}, 64'(bus.wb_rf_wen), 64'(m_wen));
        chk({n, " trace_valid"}, 64'(bus.wb_trace_valid), 64'(m_tv));
        chk({n, " dst"}, 64'(bus.wb_rf_dst), 64'(m_dst));
        chk({n, " value"}, bus.wb_rf_value, m_val);
        chk({n, " trace_pc"}, bus.wb_trace_pc, m_pc);
        chk({n, " retire_count"}, bus.wb_retire_count, m_count);
    endtask

    task automatic do_reset();
        rst = 1'b0; hold = 1'b0;
        for (int i = 0; i < 4; i++) s_valid[i] = 1'b0;
        apply();
        @(posedge clk); #1;
        chk("reset ready", 64'(rdy()), 64'd0);
        chk("reset wen", 64'(bus.wb_rf_wen), 64'd0);
        chk("reset trace_valid", 64'(bus.wb_trace_valid), 64'd0);
        chk("reset count", bus.wb_retire_count, 64'd0);
        chk("reset value", bus.wb_rf_value, 64'd0);
        rst = 1'b1;
        mreset();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        tbl[0]  = '{4'b0001, 2'b00, 1'b0, 4'b1111, 0, 1'b1};
        tbl[1]  = '{4'b1111, 2'b00, 1'b0, 4'b0001, 0, 1'b1};
        tbl[2]  = '{4'b1110, 2'b00, 1'b0, 4'b0011, 1, 1'b1};
        tbl[3]  = '{4'b1100, 2'b00, 1'b0, 4'b0111, 2, 1'b1};
        tbl[4]  = '{4'b1010, 2'b10, 1'b0, 4'b0111, 1, 1'b1};
        tbl[5]  = '{4'b0011, 2'b11, 1'b0, 4'b1101, 0, 1'b1};
        tbl[6]  = '{4'b0011, 2'b10, 1'b0, 4'b1110, 1, 1'b1};
        tbl[7]  = '{4'b1000, 2'b00, 1'b0, 4'b1111, 3, 1'b0};
        tbl[8]  = '{4'b0000, 2'b00, 1'b0, 4'b1111, -1, 1'b0};
        tbl[9]  = '{4'b1111, 2'b00, 1'b1, 4'b0000, -1, 1'b0};
        tbl[10] = '{4'b0101, 2'b01, 1'b0, 4'b1011, 0, 1'b1};
        set_data();

        foreach (tbl[t]) begin
            do_reset();
            for (int i = 0; i < 4; i++) s_valid[i] = tbl[t].valid[i];
            s_hi[0] = tbl[t].hi[0]; s_hi[1] = tbl[t].hi[1]; hold = tbl[t].hold;
            apply();
            #3;
            chk($sformatf("vec%0d ready", t), 64'(rdy()), 64'(tbl[t].er));
            @(posedge clk); #1;
            chk($sformatf("vec%0d trace_valid", t), 64'(bus.wb_trace_valid), 64'(tbl[t].g >= 0));
            chk($sformatf("vec%0d wen", t), 64'(bus.wb_rf_wen), 64'(tbl[t].wen));
            if (tbl[t].g >= 0) begin
                chk($sformatf("vec%0d pc", t), bus.wb_trace_pc, 64'h8000 + 64'(4 * tbl[t].g));
                chk($sformatf("vec%0d count", t), bus.wb_retire_count, 64'd1);
            end
        end
        set_data();

        do_reset();
        s_valid[0] = 1'b1; s_dst[0] = 5'd5; s_res[0] = 64'h1234; s_pc[0] = 64'h100;
        step("ip0_first", g);
        chk("ip0_first value", bus.wb_rf_value, 64'h1234);
        chk("ip0_first dst", 64'(bus.wb_rf_dst), 64'd5);
        chk("ip0_first count", bus.wb_retire_count, 64'd1);
        s_valid[0] = 1'b0;

        do_reset();
        for (int i = 0; i < 4; i++) begin s_valid[i] = 1'b1; s_pc[i] = 64'h200 + 64'(i); end
        for (int c = 0; c < 4; c++) begin
            step("all4", g);
            chk("all4 order pc", bus.wb_trace_pc, 64'h200 + 64'(c));
            if (g >= 0) s_valid[g] = 1'b0;
        end
        chk("all4 count", bus.wb_retire_count, 64'd4);

        do_reset();
        s_valid[1] = 1'b1; s_hi[1] = 1'b1; s_valid[2] = 1'b1; s_pc[2] = 64'h400;
        for (int c = 0; c <= LIM; c++) begin
            s_pc[1] = 64'h300 + 64'(c);
            step("starve", g);
            chk("starve pc", bus.wb_trace_pc, c < LIM ? 64'h300 + 64'(c) : 64'h400);
        end
        s_pc[1] = 64'h3ff;
        step("starve_after", g);
        chk("starve_after pc", bus.wb_trace_pc, 64'h3ff);
        s_valid[1] = 1'b0; s_hi[1] = 1'b0; s_valid[2] = 1'b0;
        set_data();

        do_reset();
        s_valid[0] = 1'b1; s_pc[0] = 64'h500; hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step("hold", g);
            chk("hold trace_valid", 64'(bus.wb_trace_valid), 64'd0);
        end
        hold = 1'b0;
        step("hold_release", g);
        chk("hold_release pc", bus.wb_trace_pc, 64'h500);
        s_valid[0] = 1'b0;

        do_reset();
        s_valid[0] = 1'b1; s_pc[0] = 64'h600;
        step("pre_rst", g);
        #2 rst = 1'b0;
        #1;
        chk("async_rst wen", 64'(bus.wb_rf_wen), 64'd0);
        chk("async_rst trace_valid", 64'(bus.wb_trace_valid), 64'd0);
        chk("async_rst count", bus.wb_retire_count, 64'd0);
        chk("async_rst pc", bus.wb_trace_pc, 64'd0);
        chk("async_rst ready", 64'(rdy()), 64'd0);
        @(posedge clk); #1;
        s_valid[0] = 1'b0; rst = 1'b1; mreset();
        step("post_rst", g);
        chk("post_rst count", bus.wb_retire_count, 64'd0);

        do_reset();
        for (int n = 0; n < 400; n++) begin
            step("rand", g);
            for (int i = 0; i < 4; i++)
                if (!s_valid[i] || g == i) begin
                    s_valid[i] = $urandom_range(0, 99) < 60;
                    s_hi[i]    = i < 2 && $urandom_range(0, 99) < 30;
                    s_en[i]    = $urandom_range(0, 3) != 0;
                    s_dst[i]   = 5'($urandom_range(0, 31));
                    s_res[i]   = {$urandom, $urandom};
                    s_pc[i]    = {$urandom, $urandom};
                end
            hold = $urandom_range(0, 19) == 0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
